// File: rtl/serialize_if.sv
// Valid/ready data-transfer interface used between streaming blocks.
// A transfer happens on every rising clock edge where valid && ready.
interface dti #(
  parameter int unsigned W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/serialize.sv
// Word-to-lane serializer: each accepted LANES*LANE_W word is emitted as
// LANES consecutive LANE_W-bit transfers, lane 0 first. The top data bit
// (eot) marks the final lane of each word. A new word can be accepted in the
// same cycle the last lane leaves, so back-to-back words have no bubble.
module serialize #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 4
) (
  input logic  clk,
  input logic  rst,
  dti.consumer din,
  dti.producer dout
);

  localparam int unsigned     IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                       state = IDLE;
  state_t                       state_nxt;
  logic [LANES-1:0][LANE_W-1:0] word_reg;
  logic [IDX_W-1:0]             idx;
  logic [IDX_W-1:0]             idx_nxt;
  logic                         busy;
  logic                         last;
  logic                         din_ready;
  logic                         in_hs;
  logic                         out_hs;

  // Parameter and interface-width sanity checks at elaboration.
  if (LANES < 2) begin : g_bad_lanes
    $error("serialize: LANES must be at least 2");
  end
  if ($bits(din.data) != int'(LANES * LANE_W)) begin : g_bad_din_w
    $error("serialize: din.data width must be LANES*LANE_W");
  end
  if ($bits(dout.data) != int'(LANE_W + 1)) begin : g_bad_dout_w
    $error("serialize: dout.data width must be LANE_W+1");
  end

  assign busy = (state == BUSY);
  assign last = (idx == LAST_IDX);

  // Input acceptance: idle, or the final lane is leaving this cycle.
  // Depends only on state and dout.ready, never on din.valid.
  always_comb begin
    din_ready = 1'b0;
    if (!busy) begin
      din_ready = 1'b1;
    end else if (last && dout.ready) begin
      din_ready = 1'b1;
    end
  end

  assign din.ready  = din_ready;
  assign dout.valid = busy;
  assign dout.data  = {last, word_reg[idx]};

  assign in_hs  = din.valid && din_ready;
  assign out_hs = busy && dout.ready;

  // Next-state and lane-counter logic; a new word always wins over finishing.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (in_hs) begin
      state_nxt = BUSY;
      idx_nxt   = '0;
    end else if (out_hs) begin
      if (last) begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end
  end

  // State and lane counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Word register: loaded on input handshake, content irrelevant after reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      word_reg <= din.data;
    end
  end

endmodule

// File: tb/tb_serialize.sv
// Self-checking bench for serialize (LANE_W=8, LANES=4).
module tb_serialize;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 4;

  typedef struct packed {
    logic [31:0]      word;
    logic [3:0][8:0]  lanes;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dti #(.W(32)) din_if ();
  dti #(.W(9))  dout_if ();

  serialize #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  exp_q[$];
  bit          rand_rdy_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [8:0]  stall_data = '0;
  vec_t        tbl[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][8:0] split(input logic [31:0] w);
    logic [3:0][8:0] r;
    for (int k = 0; k < 4; k++) r[k] = {(k == 3), w[k*8 +: 8]};
    return r;
  endfunction

  // Output monitor: pops the scoreboard on each dout handshake, checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && dout_if.valid)
        check("stall_stable", 32'(dout_if.data), 32'(stall_data));
      if (dout_if.valid && dout_if.ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_lane: got 0x%0h with empty scoreboard at %0t", dout_if.data, $time);
        end else begin
          check("lane", 32'(dout_if.data), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = dout_if.valid && !dout_if.ready;
      stall_data = dout_if.data;
    end
  end

  // Random downstream backpressure.
  always @(posedge clk) begin
    #1;
    if (rand_rdy_en) dout_if.ready = 1'($urandom_range(0, 1));
  end

  // Drive one word until accepted; expected lanes enter the scoreboard at handshake.
  task automatic send_word(input logic [31:0] w, input logic [3:0][8:0] lanes);
    bit hs = 1'b0;
    din_if.valid = 1'b1;
    din_if.data  = w;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      if (din_if.ready) begin
        hs = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(lanes[k]);
      end
      @(posedge clk);
      #1;
    end
    din_if.valid = 1'b0;
    check("din_handshake", 32'(hs), 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          er[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    bit          ev[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    bit          hs;
    logic [31:0] w;

    tbl[0].word = 32'h44332211; tbl[0].lanes = {9'h144, 9'h033, 9'h022, 9'h011};
    tbl[1].word = 32'hFF00A55A; tbl[1].lanes = {9'h1FF, 9'h000, 9'h0A5, 9'h05A};
    tbl[2].word = 32'h80000001; tbl[2].lanes = {9'h180, 9'h000, 9'h000, 9'h001};

    din_if.valid  = 1'b0;
    din_if.data   = '0;
    dout_if.ready = 1'b0;

    // Reset behaviour
    @(negedge clk);
    check("rst_dout_valid", 32'(dout_if.valid), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_dout_valid", 32'(dout_if.valid), 32'd0);
    check("post_rst_din_ready", 32'(din_if.ready), 32'd1);
    @(posedge clk); #1;
    dout_if.ready = 1'b1;

    // Table-driven single words: latency of one cycle, four consecutive lanes, then idle
    for (int i = 0; i < 3; i++) begin
      send_word(tbl[i].word, tbl[i].lanes);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("lat_valid", 32'(dout_if.valid), 32'd1);
      end
      @(negedge clk);
      check("idle_after_word", 32'(dout_if.valid), 32'd0);
      drain();
    end

    // Back-to-back words with no bubble
    din_if.valid = 1'b1;
    din_if.data  = 32'hDDCCBBAA;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("b2b_din_ready", 32'(din_if.ready), 32'(er[c]));
      check("b2b_dout_valid", 32'(dout_if.valid), 32'(ev[c]));
      hs = din_if.valid && din_if.ready;
      if (hs) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(split(din_if.data)[k]);
      end
      @(posedge clk); #1;
      if (hs) begin
        if (din_if.data == 32'hDDCCBBAA) din_if.data = 32'h04030201;
        else din_if.valid = 1'b0;
      end
    end
    din_if.valid = 1'b0;
    drain();

    // Stall on the last lane with the next word waiting
    din_if.valid = 1'b1;
    din_if.data  = 32'h13579BDF;
    @(negedge clk);
    check("stall_first_ready", 32'(din_if.ready), 32'd1);
    for (int k = 0; k < 4; k++) exp_q.push_back(split(32'h13579BDF)[k]);
    @(posedge clk); #1;
    din_if.data = 32'h2468ACE0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_mid_ready", 32'(din_if.ready), 32'd0);
      @(posedge clk);
    end
    #1;
    dout_if.ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_din_ready", 32'(din_if.ready), 32'd0);
      check("stall_last_lane", 32'(dout_if.data), 32'h113);
      @(posedge clk);
    end
    #1;
    dout_if.ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 32'(din_if.ready), 32'd1);
    for (int k = 0; k < 4; k++) exp_q.push_back(split(32'h2468ACE0)[k]);
    @(posedge clk); #1;
    din_if.valid = 1'b0;
    drain();

    // Random backpressure over 100 random words
    rand_rdy_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      w = $urandom;
      send_word(w, split(w));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rand_rdy_en = 1'b0;
    @(posedge clk); #2;
    dout_if.ready = 1'b1;
    @(posedge clk); #1;

    // Reset after lane 1 discards the rest of the word
    send_word(32'h44332211, tbl[0].lanes);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dout_valid", 32'(dout_if.valid), 32'd0);
    check("midrst_din_ready", 32'(din_if.ready), 32'd1);
    @(posedge clk); #1;
    send_word(32'h88776655, {9'h188, 9'h077, 9'h066, 9'h055});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serialize.md
SERIALIZE -- requirements
Module: serialize

Interface
REQ-001 SHALL have parameter LANE_W, default 8: width of one output lane in bits; legal range 1 and up.
REQ-002 SHALL have parameter LANES, default 4: number of lanes per input word; legal range 2 and up.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 din  dti.consumer  data LANES*LANE_W  wide input word; lane k is din.data[k*LANE_W +: LANE_W].
REQ-006 dout  dti.producer  data LANE_W+1  one lane per transfer; bits [LANE_W-1:0] are lane data, bit LANE_W is eot.

Function
REQ-007 SHALL emit each accepted input word as LANES consecutive dout transfers: lane 0 first, lane LANES-1 last.
REQ-008 SHALL set eot=1 on the lane LANES-1 transfer only, and eot=0 on all other lanes.
REQ-009 SHALL hold an internal word register, a valid flag "busy", and a lane counter idx of width $clog2(LANES).
REQ-010 SHALL have two states: IDLE (busy=0) and BUSY (busy=1).
REQ-011 dout.valid SHALL equal busy; dout.data SHALL be {idx==LANES-1, word_reg lane idx}.
REQ-012 din.ready SHALL be 1 when IDLE, or when BUSY and idx==LANES-1 and dout.ready==1; otherwise 0.
REQ-013 A din handshake is din.valid && din.ready; on it, the block SHALL load word_reg with din.data, set busy=1 and set idx=0.
REQ-014 A dout handshake is dout.valid && dout.ready; on it with idx<LANES-1, the block SHALL increment idx and hold word_reg.
REQ-015 On a dout handshake with idx==LANES-1 and no simultaneous din handshake, SHALL clear busy and set idx=0.
REQ-016 When the last-lane dout handshake and a din handshake occur in the same cycle, SHALL load the new word and stay BUSY with idx=0, leaving no bubble.
REQ-017 With dout.valid=1 and dout.ready=0, dout.data and idx SHALL stay stable; no lane may be skipped or repeated.
REQ-018 Latency: first lane valid the cycle after the din handshake; sustained throughput is one lane per cycle under continuous ready.
REQ-019 din.ready SHALL not depend combinationally on din.valid.
REQ-020 SHALL raise an elaboration $error if LANES<2, or if $size(din.data)!=LANES*LANE_W, or if $size(dout.data)!=LANE_W+1.

Reset
REQ-021 While rst=1 at the clock edge, SHALL clear busy to 0 and idx to 0; word_reg content is don't-care.
REQ-022 During and after reset: dout.valid=0 and din.ready=1 from the first cycle after reset until the first din handshake.
REQ-023 Reset mid-word SHALL discard the remaining lanes; no partial lane may appear after reset.
REQ-024 Power-up initial value of busy SHALL be 0.

Verification (LANE_W=8, LANES=4)
REQ-025 Single word: din=0x44332211, valid for 1 handshake, dout.ready=1 -> dout 0x011,0x022,0x033,0x144 on 4 consecutive cycles starting 1 cycle after din handshake; then dout.valid=0.
REQ-026 Back-to-back: words 0xDDCCBBAA then 0x04030201 held valid, dout.ready=1 -> 8 consecutive lanes AA,BB,CC,DD(eot),01,02,03,04(eot) with no idle cycle; din.ready high only on the IDLE cycle and the eot-handshake cycles.
REQ-027 Backpressure: random dout.ready (50%) over 100 random words -> output stream equals the input lanes in order; each eot is on every 4th lane; data is stable while valid && !ready.
REQ-028 Stall at last lane: dout.ready=0 while idx=3 with din.valid=1 -> din.ready=0 and the next word is not loaded until dout.ready=1.
REQ-029 Reset mid-word: rst=1 after lane 1 of 0x44332211 -> next cycle dout.valid=0 and din.ready=1; the next word 0x88776655 emits 0x55,0x66,0x77,0x188.
REQ-030 Upstream buff: with buff inserted on din, full throughput is kept (1 lane/cycle) and order matches REQ-026.
